bmu_soft_pipe: RTL

- Parametrised successor to the fixed hard-decision branch metric unit of the rate-1/2, 4-state Viterbi decoder.
- Accepts one received symbol (two code bits) per handshake, in soft-decision or hard-decision mode.
- Applies a programmable puncturing pattern, marking punctured bits as erasures.
- Emits registered branch metrics for all four candidate codewords (00, 01, 10, 11) to the ACS array through a 2-stage valid/ready pipeline.

---
 rtl/bmu_soft_pipe_if.sv | 27 ++
 rtl/bmu_soft_pipe.sv | 132 +++++++++++++
 2 files changed

// File: rtl/bmu_soft_pipe_if.sv
// Symbol-in / metrics-out handshake bundle for the branch metric unit.
// The slave side is the BMU; the master side is the upstream source plus the ACS sink.
interface bmu_soft_pipe_if #(
  parameter int SOFT_W = 3,
  parameter int BM_W   = SOFT_W + 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2*SOFT_W-1:0]   in_sym;
  logic                  out_valid;
  logic                  out_ready;
  logic [BM_W-1:0]       bm00;
  logic [BM_W-1:0]       bm01;
  logic [BM_W-1:0]       bm10;
  logic [BM_W-1:0]       bm11;
  logic [1:0]            out_erase;

  modport master (
    output in_valid, in_sym, out_ready,
    input  in_ready, out_valid, bm00, bm01, bm10, bm11, out_erase
  );

  modport slave (
    input  in_valid, in_sym, out_ready,
    output in_ready, out_valid, bm00, bm01, bm10, bm11, out_erase
  );
endinterface

// File: rtl/bmu_soft_pipe.sv
// Soft/hard branch metric unit with programmable puncturing for a rate-1/2 Viterbi decoder.
// Stage 1 captures symbol, erase mask and mode; stage 2 registers the four branch metrics.
module bmu_soft_pipe #(
  parameter int SOFT_W   = 3,
  parameter int BM_W     = SOFT_W + 1,
  parameter int PUNC_MAX = 4,
  parameter int PL_W     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode_soft,
  input  logic                  punc_en,
  input  logic [2*PUNC_MAX-1:0] punc_pattern,
  input  logic [PL_W-1:0]       punc_len,
  input  logic                  frame_start,
  bmu_soft_pipe_if.slave        bus
);
  localparam int PH_W = (PUNC_MAX > 1) ? $clog2(PUNC_MAX) : 1;
  localparam logic [SOFT_W-1:0] X_MAX = '1;

  logic                  s1_valid_q;
  logic [2*SOFT_W-1:0]   s1_sym_q;
  logic [1:0]            s1_erase_q;
  logic                  s1_soft_q;
  logic                  s2_valid_q;
  logic [BM_W-1:0]       bm00_q, bm01_q, bm10_q, bm11_q;
  logic [BM_W-1:0]       bm00_d, bm01_d, bm10_d, bm11_d;
  logic [1:0]            s2_erase_q;
  logic [PH_W-1:0]       phase_q, phase_d;

  logic                  adv;
  logic                  accept;
  logic [PL_W-1:0]       len_eff;
  logic [PH_W-1:0]       sym_phase;
  logic [PL_W-1:0]       phase_inc;
  logic [2*PUNC_MAX-1:0] pat_shift;
  logic [1:0]            erase_d;

  assign adv    = !s2_valid_q || bus.out_ready;
  assign accept = bus.in_valid && adv;

  // Out-of-range periods are folded into 1..PUNC_MAX so the phase always wraps.
  always_comb begin
    len_eff = punc_len;
    if (punc_len == '0) begin
      len_eff = PL_W'(1);
    end else if (punc_len > PL_W'(PUNC_MAX)) begin
      len_eff = PL_W'(PUNC_MAX);
    end
  end

  assign sym_phase = frame_start ? '0 : phase_q;
  assign phase_inc = PL_W'(sym_phase) + PL_W'(1);
  assign pat_shift = punc_pattern >> {sym_phase, 1'b0};
  assign erase_d   = punc_en ? ~pat_shift[1:0] : 2'b00;

  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      phase_d = (phase_inc >= len_eff) ? '0 : PH_W'(phase_inc);
    end else if (frame_start) begin
      phase_d = '0;
    end
  end

  // Per-bit distances to expected 0 and 1; an erased bit contributes nothing.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bit
    logic [SOFT_W-1:0] x;
    logic [BM_W-1:0]   dist0;
    logic [BM_W-1:0]   dist1;

    assign x = s1_sym_q[gi*SOFT_W +: SOFT_W];

    always_comb begin
      dist0 = '0;
      dist1 = '0;
      if (!s1_erase_q[gi]) begin
        if (s1_soft_q) begin
          dist0 = BM_W'(x);
          dist1 = BM_W'(X_MAX - x);
        end else begin
          dist0 = BM_W'(x[SOFT_W-1]);
          dist1 = BM_W'(!x[SOFT_W-1]);
        end
      end
    end
  end

  // Index 1 is c1 (first codeword bit), index 0 is c0.
  assign bm00_d = g_bit[1].dist0 + g_bit[0].dist0;
  assign bm01_d = g_bit[1].dist0 + g_bit[0].dist1;
  assign bm10_d = g_bit[1].dist1 + g_bit[0].dist0;
  assign bm11_d = g_bit[1].dist1 + g_bit[0].dist1;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_sym_q   <= '0;
      s1_erase_q <= '0;
      s1_soft_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      bm00_q     <= '0;
      bm01_q     <= '0;
      bm10_q     <= '0;
      bm11_q     <= '0;
      s2_erase_q <= '0;
    end else begin
      phase_q <= phase_d;
      if (adv) begin
        s1_valid_q <= bus.in_valid;
        s1_sym_q   <= bus.in_sym;
        s1_erase_q <= erase_d;
        s1_soft_q  <= mode_soft;
        s2_valid_q <= s1_valid_q;
        bm00_q     <= bm00_d;
        bm01_q     <= bm01_d;
        bm10_q     <= bm10_d;
        bm11_q     <= bm11_d;
        s2_erase_q <= s1_erase_q;
      end
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = s2_valid_q;
  assign bus.bm00      = bm00_q;
  assign bus.bm01      = bm01_q;
  assign bus.bm10      = bm10_q;
  assign bus.bm11      = bm11_q;
  assign bus.out_erase = s2_erase_q;
endmodule
